// File: rtl/frame_readout_sequencer_if.sv
// Signal bundle between the frame readout sequencer and its HPS / CCD / SDRAM peers.
// The oCHECKSUM member exists only when FRS_CHECKSUM_EN is defined.
interface frame_readout_sequencer_if;
    logic        iSTART_REQ;
    logic        iFVAL;
    logic        iDVAL;
    logic        iRD_REQ;
    logic        iRD_ACK;
    logic [15:0] iRD_DATA;
    logic        oCAP_START;
    logic        oCAP_END;
    logic        oWR_LOAD;
    logic        oRD_LOAD;
    logic        oFIFO_RD;
    logic [15:0] oWORD;
    logic        oWORD_VALID;
    logic [8:0]  oROW;
    logic [5:0]  oCOL;
    logic        oDONE;
    logic        oERR;
    logic [2:0]  oSTATE;
`ifdef FRS_CHECKSUM_EN
    logic [15:0] oCHECKSUM;
`endif

    modport master (
        output iSTART_REQ, iFVAL, iDVAL, iRD_REQ, iRD_ACK, iRD_DATA,
        input  oCAP_START, oCAP_END, oWR_LOAD, oRD_LOAD, oFIFO_RD, oWORD,
               oWORD_VALID, oROW, oCOL, oDONE, oERR, oSTATE
`ifdef FRS_CHECKSUM_EN
        , input oCHECKSUM
`endif
    );

    modport slave (
        input  iSTART_REQ, iFVAL, iDVAL, iRD_REQ, iRD_ACK, iRD_DATA,
        output oCAP_START, oCAP_END, oWR_LOAD, oRD_LOAD, oFIFO_RD, oWORD,
               oWORD_VALID, oROW, oCOL, oDONE, oERR, oSTATE
`ifdef FRS_CHECKSUM_EN
        , output oCHECKSUM
`endif
    );
endinterface

// File: rtl/frame_readout_sequencer.sv
// Sequences one binarised frame: arm capture, count packed pixel writes, then serve HPS word reads.
// Optional FRS_CHECKSUM_EN adds a modulo-2^16 sum of every word presented to the HPS.
module frame_readout_sequencer #(
    parameter int unsigned H_PIXELS = 640,
    parameter int unsigned V_LINES  = 480,
    parameter int unsigned PACK     = 16,
    parameter logic [23:0] TIMEOUT  = 24'hFFFFFF
) (
    input logic iCLK,
    input logic iRST,
    frame_readout_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SYNC    = 3'd2,
        S_ARMED   = 3'd3,
        S_CAPTURE = 3'd4,
        S_READOUT = 3'd5,
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } state_t;

    localparam int unsigned NPIX     = H_PIXELS * V_LINES;
    localparam int unsigned WPL      = H_PIXELS / PACK;
    localparam logic [18:0] LAST_PIX = 19'(NPIX - 1);
    localparam logic [8:0]  LAST_ROW = 9'(V_LINES - 1);
    localparam logic [5:0]  LAST_COL = 6'(WPL - 1);

    state_t      state_q, state_d;
    logic        start_q, fval_q;
    logic [18:0] pix_q, pix_d;
    logic [23:0] tmo_q, tmo_d;
    logic        fifo_rd_q, fifo_rd_d;
    logic        valid_q, valid_d;
    logic [15:0] word_q, word_d;
    logic [8:0]  row_q, row_d;
    logic [5:0]  col_q, col_d;
    logic        err_q, err_d;
    logic        cap_end_q, cap_end_d;
`ifdef FRS_CHECKSUM_EN
    logic [15:0] cks_q, cks_d;
`endif

    logic ack_eff, tmo_hit;
    assign ack_eff = bus.iRD_ACK && valid_q;
    assign tmo_hit = (tmo_q == TIMEOUT - 24'd1);

    always_comb begin
        state_d   = state_q;
        pix_d     = pix_q;
        tmo_d     = '0;
        fifo_rd_d = 1'b0;
        valid_d   = valid_q;
        word_d    = word_q;
        row_d     = row_q;
        col_d     = col_q;
        err_d     = err_q;
        cap_end_d = 1'b0;
`ifdef FRS_CHECKSUM_EN
        cks_d     = cks_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.iSTART_REQ && !start_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_SYNC;
`ifdef FRS_CHECKSUM_EN
                cks_d   = '0;
`endif
            end
            S_SYNC: begin
                tmo_d = tmo_q + 24'd1;
                if (!bus.iFVAL)   state_d = S_ARMED;
                else if (tmo_hit) state_d = S_ERR;
            end
            S_ARMED: begin
                tmo_d = tmo_q + 24'd1;
                if (bus.iFVAL && !fval_q) state_d = S_CAPTURE;
                else if (tmo_hit)         state_d = S_ERR;
            end
            S_CAPTURE: begin
                tmo_d = tmo_q + 24'd1;
                if (bus.iDVAL && pix_q == LAST_PIX) begin
                    pix_d     = pix_q + 19'd1;
                    state_d   = S_READOUT;
                    cap_end_d = 1'b1;
                end else begin
                    if (bus.iDVAL) pix_d = pix_q + 19'd1;
                    if (!bus.iFVAL && fval_q) state_d = S_ERR;
                    else if (tmo_hit)         state_d = S_ERR;
                end
            end
            S_READOUT: begin
                if (fifo_rd_q) begin
                    word_d  = bus.iRD_DATA;
                    valid_d = 1'b1;
`ifdef FRS_CHECKSUM_EN
                    cks_d   = cks_q + bus.iRD_DATA;
`endif
                end
                if (ack_eff) begin
                    valid_d = 1'b0;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) state_d = S_DONE;
                        else                   row_d = row_q + 9'd1;
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
                // Ack is resolved first, so a same-cycle request sees the word slot already freed.
                if (bus.iRD_REQ && state_d != S_DONE) begin
                    if (fifo_rd_q || (valid_q && !ack_eff)) err_d = 1'b1;
                    else                                     fifo_rd_d = 1'b1;
                end
            end
            S_DONE: begin
                valid_d = 1'b0;
                if (!bus.iSTART_REQ) state_d = S_IDLE;
            end
            S_ERR: begin
                if (!bus.iSTART_REQ) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!bus.iSTART_REQ && state_q inside {S_LOAD, S_SYNC, S_ARMED, S_CAPTURE, S_READOUT}) begin
            state_d   = S_IDLE;
            cap_end_d = (state_q == S_ARMED) || (state_q == S_CAPTURE);
        end
        if (state_d == S_ERR && state_q != S_ERR) begin
            err_d     = 1'b1;
            cap_end_d = 1'b1;
        end
        if (state_d == S_IDLE) begin
            err_d     = 1'b0;
            pix_d     = '0;
            row_d     = '0;
            col_d     = '0;
            valid_d   = 1'b0;
            fifo_rd_d = 1'b0;
        end
        if (state_d != state_q) tmo_d = '0;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            fval_q    <= 1'b0;
            pix_q     <= '0;
            tmo_q     <= '0;
            fifo_rd_q <= 1'b0;
            valid_q   <= 1'b0;
            word_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            err_q     <= 1'b0;
            cap_end_q <= 1'b0;
`ifdef FRS_CHECKSUM_EN
            cks_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            start_q   <= bus.iSTART_REQ;
            fval_q    <= bus.iFVAL;
            pix_q     <= pix_d;
            tmo_q     <= tmo_d;
            fifo_rd_q <= fifo_rd_d;
            valid_q   <= valid_d;
            word_q    <= word_d;
            row_q     <= row_d;
            col_q     <= col_d;
            err_q     <= err_d;
            cap_end_q <= cap_end_d;
`ifdef FRS_CHECKSUM_EN
            cks_q     <= cks_d;
`endif
        end
    end

    assign bus.oCAP_START  = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    assign bus.oCAP_END    = cap_end_q;
    assign bus.oWR_LOAD    = (state_q == S_LOAD);
    assign bus.oRD_LOAD    = (state_q == S_LOAD);
    assign bus.oFIFO_RD    = fifo_rd_q;
    assign bus.oWORD       = word_q;
    assign bus.oWORD_VALID = valid_q;
    assign bus.oROW        = row_q;
    assign bus.oCOL        = col_q;
    assign bus.oDONE       = (state_q == S_DONE);
    assign bus.oERR        = err_q;
    assign bus.oSTATE      = state_q;
`ifdef FRS_CHECKSUM_EN
    assign bus.oCHECKSUM   = cks_q;
`endif
endmodule

// File: tb/tb_frame_readout_sequencer.sv
// Scoreboard bench for frame_readout_sequencer on a reduced 32x4 frame (2 words per line, 8 words).
// Expected words and capture-end pulses are queued by the stimulus and popped by a monitor.
module tb_frame_readout_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_readout_sequencer_if bus ();

    frame_readout_sequencer #(
        .H_PIXELS(32),
        .V_LINES (4),
        .PACK    (16),
        .TIMEOUT (24'd300)
    ) dut (
        .iCLK(clk),
        .iRST(rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [15:0] w;
        logic [8:0]  r;
        logic [5:0]  c;
    } word_t;

    int          checks   = 0;
    int          failures = 0;
    word_t       wq[$];
    logic [2:0]  capq[$];
    int          exp_fifo_rd  = 0;
    int          seen_fifo_rd = 0;
    logic        valid_prev   = 1'b0;
    word_t       mw;
    logic [2:0]  mc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every newly presented word and every capture-end pulse against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.oWORD_VALID && !valid_prev) begin
                chk("word_expected", 32'(wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    mw = wq.pop_front();
                    chk("mon_word", 32'(bus.oWORD), 32'(mw.w));
                    chk("mon_row",  32'(bus.oROW),  32'(mw.r));
                    chk("mon_col",  32'(bus.oCOL),  32'(mw.c));
                end
            end
            if (bus.oCAP_END) begin
                chk("cap_end_expected", 32'(capq.size() != 0), 1);
                if (capq.size() != 0) begin
                    mc = capq.pop_front();
                    chk("cap_end_state", 32'(bus.oSTATE), 32'(mc));
                end
            end
            if (bus.oFIFO_RD) seen_fifo_rd++;
        end
        valid_prev = bus.oWORD_VALID;
    end

    task automatic outs_zero(input string tag);
        chk({tag, "_state"},     32'(bus.oSTATE), 0);
        chk({tag, "_cap_start"}, 32'(bus.oCAP_START), 0);
        chk({tag, "_cap_end"},   32'(bus.oCAP_END), 0);
        chk({tag, "_wr_load"},   32'(bus.oWR_LOAD), 0);
        chk({tag, "_rd_load"},   32'(bus.oRD_LOAD), 0);
        chk({tag, "_fifo_rd"},   32'(bus.oFIFO_RD), 0);
        chk({tag, "_word"},      32'(bus.oWORD), 0);
        chk({tag, "_valid"},     32'(bus.oWORD_VALID), 0);
        chk({tag, "_row"},       32'(bus.oROW), 0);
        chk({tag, "_col"},       32'(bus.oCOL), 0);
        chk({tag, "_done"},      32'(bus.oDONE), 0);
        chk({tag, "_err"},       32'(bus.oERR), 0);
    endtask

    // n pixel strobes on alternate cycles; returns right after the edge that sampled the last one.
    task automatic capture_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.iDVAL = 1'b1;
            step();
            bus.iDVAL = 1'b0;
            if (i != n - 1) step();
        end
    endtask

    task automatic arm_to_capture(input string tag);
        bus.iFVAL      = 1'b0;
        bus.iSTART_REQ = 1'b1;
        step();
        step();
        step();
        bus.iFVAL = 1'b1;
        step();
        chk({tag, "_capture_state"}, 32'(bus.oSTATE), 4);
    endtask

    task automatic fetch(input logic [15:0] d, input logic [8:0] r, input logic [5:0] c);
        wq.push_back('{w: d, r: r, c: c});
        exp_fifo_rd++;
        bus.iRD_DATA = d;
        bus.iRD_REQ  = 1'b1;
        step();
        bus.iRD_REQ = 1'b0;
        chk("fetch_fifo_rd", 32'(bus.oFIFO_RD), 1);
        chk("fetch_valid_early", 32'(bus.oWORD_VALID), 0);
        step();
        chk("fetch_fifo_rd_drop", 32'(bus.oFIFO_RD), 0);
        chk("fetch_valid", 32'(bus.oWORD_VALID), 1);
        chk("fetch_word", 32'(bus.oWORD), 32'(d));
    endtask

    task automatic ack();
        bus.iRD_ACK = 1'b1;
        step();
        bus.iRD_ACK = 1'b0;
    endtask

    initial begin
        int k;
        bus.iSTART_REQ = 1'b0;
        bus.iFVAL      = 1'b0;
        bus.iDVAL      = 1'b0;
        bus.iRD_REQ    = 1'b0;
        bus.iRD_ACK    = 1'b0;
        bus.iRD_DATA   = '0;
        rst = 1'b1;
        repeat (3) step();
        outs_zero("reset");
        rst = 1'b0;
        step();

        // Frame A: full capture and readout, start raised while iFVAL is high.
        bus.iFVAL      = 1'b1;
        bus.iSTART_REQ = 1'b1;
        step();
        chk("a_load_state", 32'(bus.oSTATE), 1);
        chk("a_wr_load", 32'(bus.oWR_LOAD), 1);
        chk("a_rd_load", 32'(bus.oRD_LOAD), 1);
        step();
        chk("a_sync_state", 32'(bus.oSTATE), 2);
        chk("a_wr_load_end", 32'(bus.oWR_LOAD), 0);
        chk("a_rd_load_end", 32'(bus.oRD_LOAD), 0);
        repeat (3) step();
        chk("a_sync_hold", 32'(bus.oSTATE), 2);
        chk("a_sync_cap_start", 32'(bus.oCAP_START), 0);
        bus.iFVAL = 1'b0;
        step();
        chk("a_armed_state", 32'(bus.oSTATE), 3);
        chk("a_armed_cap_start", 32'(bus.oCAP_START), 1);
        step();
        chk("a_armed_hold", 32'(bus.oSTATE), 3);
        bus.iFVAL = 1'b1;
        step();
        chk("a_capture_state", 32'(bus.oSTATE), 4);
        chk("a_capture_cap_start", 32'(bus.oCAP_START), 1);
        capq.push_back(3'd5);
        capture_n(127);
        step();
        chk("a_not_yet_end", 32'(bus.oCAP_END), 0);
        chk("a_still_capture", 32'(bus.oSTATE), 4);
        capture_n(1);
        chk("a_cap_end_pulse", 32'(bus.oCAP_END), 1);
        chk("a_readout_state", 32'(bus.oSTATE), 5);
        chk("a_cap_start_off", 32'(bus.oCAP_START), 0);
        bus.iDVAL = 1'b1;
        repeat (3) step();
        bus.iDVAL = 1'b0;
        chk("a_extra_dval_end", 32'(bus.oCAP_END), 0);
        chk("a_extra_dval_state", 32'(bus.oSTATE), 5);

        fetch(16'd1, 9'd0, 6'd0);
        ack();
        chk("a_ack1_valid", 32'(bus.oWORD_VALID), 0);
        chk("a_ack1_col", 32'(bus.oCOL), 1);
        ack();
        chk("a_stray_ack_col", 32'(bus.oCOL), 1);
        chk("a_stray_ack_row", 32'(bus.oROW), 0);
        fetch(16'd2, 9'd0, 6'd1);
        ack();
        chk("a_wrap_row", 32'(bus.oROW), 1);
        chk("a_wrap_col", 32'(bus.oCOL), 0);
        fetch(16'd3, 9'd1, 6'd0);
        // Same-cycle ack and request for word 4.
        wq.push_back('{w: 16'd4, r: 9'd1, c: 6'd1});
        exp_fifo_rd++;
        bus.iRD_DATA = 16'd4;
        bus.iRD_REQ  = 1'b1;
        bus.iRD_ACK  = 1'b1;
        step();
        bus.iRD_REQ = 1'b0;
        bus.iRD_ACK = 1'b0;
        chk("a_ackreq_fifo_rd", 32'(bus.oFIFO_RD), 1);
        chk("a_ackreq_valid", 32'(bus.oWORD_VALID), 0);
        chk("a_ackreq_err", 32'(bus.oERR), 0);
        step();
        chk("a_ackreq_word_valid", 32'(bus.oWORD_VALID), 1);
        chk("a_ackreq_word", 32'(bus.oWORD), 4);
        ack();
        for (k = 4; k < 8; k++) begin
            fetch(16'(k + 1), 9'(k / 2), 6'(k % 2));
            ack();
        end
        chk("a_done_state", 32'(bus.oSTATE), 6);
        chk("a_done_flag", 32'(bus.oDONE), 1);
        chk("a_done_valid", 32'(bus.oWORD_VALID), 0);
        chk("a_done_err", 32'(bus.oERR), 0);
`ifdef FRS_CHECKSUM_EN
        chk("a_checksum", 32'(bus.oCHECKSUM), 36);
`endif
        step();
        chk("a_done_hold", 32'(bus.oSTATE), 6);
        bus.iSTART_REQ = 1'b0;
        step();
        chk("a_idle_state", 32'(bus.oSTATE), 0);
        chk("a_idle_done", 32'(bus.oDONE), 0);

        // Frame B: iFVAL falls before the terminal pixel count.
        arm_to_capture("b");
        capture_n(50);
        step();
        capq.push_back(3'd7);
        bus.iFVAL = 1'b0;
        step();
        chk("b_err_state", 32'(bus.oSTATE), 7);
        chk("b_err_flag", 32'(bus.oERR), 1);
        chk("b_err_cap_end", 32'(bus.oCAP_END), 1);
        chk("b_err_cap_start", 32'(bus.oCAP_START), 0);
        step();
        chk("b_err_cap_end_drop", 32'(bus.oCAP_END), 0);
        chk("b_err_hold", 32'(bus.oSTATE), 7);
        bus.iSTART_REQ = 1'b0;
        step();
        chk("b_idle_state", 32'(bus.oSTATE), 0);
        chk("b_idle_err", 32'(bus.oERR), 0);

        // Frame C: synchronous reset in the middle of capture.
        arm_to_capture("c");
        capture_n(50);
        step();
        rst            = 1'b1;
        bus.iSTART_REQ = 1'b0;
        step();
        outs_zero("c_reset");
        rst = 1'b0;
        step();
        chk("c_after_reset_cap_end", 32'(bus.oCAP_END), 0);

        // Frame D: request while a word is still valid, then abort from readout.
        arm_to_capture("d");
        capq.push_back(3'd5);
        capture_n(128);
        step();
        chk("d_readout_state", 32'(bus.oSTATE), 5);
        fetch(16'hA5A5, 9'd0, 6'd0);
        bus.iRD_REQ = 1'b1;
        step();
        bus.iRD_REQ = 1'b0;
        chk("d_proto_err", 32'(bus.oERR), 1);
        chk("d_proto_no_fifo_rd", 32'(bus.oFIFO_RD), 0);
        chk("d_proto_state", 32'(bus.oSTATE), 5);
        chk("d_proto_word_kept", 32'(bus.oWORD), 32'h0000A5A5);
        step();
        chk("d_proto_no_fifo_rd2", 32'(bus.oFIFO_RD), 0);
        chk("d_proto_err_sticky", 32'(bus.oERR), 1);
        bus.iSTART_REQ = 1'b0;
        step();
        chk("d_abort_state", 32'(bus.oSTATE), 0);
        chk("d_abort_err", 32'(bus.oERR), 0);
        chk("d_abort_valid", 32'(bus.oWORD_VALID), 0);
        chk("d_abort_cap_end", 32'(bus.oCAP_END), 0);

        // Frame E: iFVAL never drops in SYNC, so the timeout must fire.
        bus.iFVAL      = 1'b1;
        bus.iSTART_REQ = 1'b1;
        step();
        step();
        chk("e_sync_state", 32'(bus.oSTATE), 2);
        capq.push_back(3'd7);
        for (int i = 0; i < 400 && bus.oSTATE != 3'd7; i++) step();
        chk("e_timeout_state", 32'(bus.oSTATE), 7);
        chk("e_timeout_err", 32'(bus.oERR), 1);
        step();
        bus.iSTART_REQ = 1'b0;
        step();
        chk("e_idle_state", 32'(bus.oSTATE), 0);
        chk("e_idle_err", 32'(bus.oERR), 0);
        step();

        chk("words_all_seen", 32'(wq.size()), 0);
        chk("cap_end_all_seen", 32'(capq.size()), 0);
        chk("fifo_rd_count", 32'(seen_fifo_rd), 32'(exp_fifo_rd));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_readout_sequencer.md
Name: frame_readout_sequencer

Overview:
- Sequences one binarised 640x480 frame from camera to HPS.
- Arms the CCD capture block on a frame boundary, counts packed pixel writes into SDRAM write port 1, then closes capture.
- Serves HPS word reads from SDRAM read port 1 with a valid/ack handshake, replacing the free-running HPS-toggled read clock.
- Sits between the HPS PIO signals, the CCD capture block and the 4-port SDRAM controller FIFOs.

Parameters:
- H_PIXELS, 640, pixels per line
- V_LINES, 480, lines per frame
- PACK, 16, binary pixels per SDRAM word; H_PIXELS must be a multiple of PACK
- TIMEOUT, 24'hFFFFFF, maximum cycles allowed in SYNC/ARMED/CAPTURE before error

Ports:
- iCLK  in  1  system clock; all inputs are synchronous to it
- iRST  in  1  synchronous reset, active-high
- iSTART_REQ  in  1  HPS level request: 1 = acquire frame, 0 = release/abort
- iFVAL  in  1  frame valid from sensor, already synchronised to iCLK
- iDVAL  in  1  one-cycle strobe per captured pixel
- iRD_REQ  in  1  HPS one-cycle strobe: fetch next word
- iRD_ACK  in  1  HPS one-cycle strobe: current word consumed
- iRD_DATA  in  16  SDRAM read-FIFO output; 1-cycle read latency
- oCAP_START  out  1  to CCD capture iSTART
- oCAP_END  out  1  to CCD capture iEND
- oWR_LOAD  out  1  one-cycle load pulse, write port 1
- oRD_LOAD  out  1  one-cycle load pulse, read port 1
- oFIFO_RD  out  1  read-FIFO pop strobe
- oWORD  out  16  word presented to HPS
- oWORD_VALID  out  1  oWORD holds unacknowledged data
- oROW  out  9  line index of oWORD (0..V_LINES-1)
- oCOL  out  6  word index within line (0..H_PIXELS/PACK-1)
- oDONE  out  1  full frame delivered
- oERR  out  1  timeout, short frame or protocol error
- oSTATE  out  3  state encoding, for LEDR

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-operation returns to IDLE next cycle with no oCAP_END pulse.
- Encodings: IDLE=0, LOAD=1, SYNC=2, ARMED=3, CAPTURE=4, READOUT=5, DONE=6, ERR=7.
- IDLE: detect iSTART_REQ 0->1 (registered edge) -> LOAD.
- LOAD: oWR_LOAD = oRD_LOAD = 1 for exactly 1 cycle -> SYNC.
- SYNC: wait for iFVAL = 0 -> ARMED.
- ARMED: oCAP_START = 1 (held through CAPTURE); on iFVAL rising -> CAPTURE.
- CAPTURE: 19-bit pixel counter increments on iDVAL. When the count reaches H_PIXELS*V_LINES (307200):
  - oCAP_START = 0 and oCAP_END = 1 for 1 cycle -> READOUT.
  - Any iDVAL after terminal count is ignored.
- Short frame: iFVAL falling in CAPTURE before terminal count -> ERR.
- Timeout: a 24-bit counter clears on each state entry and runs in SYNC/ARMED/CAPTURE. Reaching TIMEOUT -> ERR.
- READOUT handshake:
  - iRD_REQ at cycle n with oWORD_VALID = 0 and no fetch pending -> oFIFO_RD = 1 at n+1.
  - At n+2: oWORD <= iRD_DATA, oWORD_VALID = 1, oROW/oCOL = current position.
  - iRD_ACK clears oWORD_VALID next cycle and advances oCOL. oCOL wraps 39->0 and increments oROW.
  - iRD_REQ while valid or pending -> oERR sticky, request ignored, state unchanged.
  - iRD_ACK while oWORD_VALID = 0 -> ignored.
  - iRD_REQ and iRD_ACK in the same cycle: process ack first; the req is then accepted.
- Final ack of word 19199 (row 479, col 39) -> DONE. oDONE = 1, oWORD_VALID = 0.
- DONE: hold until iSTART_REQ = 0 -> IDLE; oDONE clears.
- ERR: oERR = 1, oCAP_START = 0, oCAP_END = 1 for 1 cycle on entry. Hold until iSTART_REQ = 0 -> IDLE, which clears oERR.
- Abort: iSTART_REQ = 0 in LOAD..READOUT -> IDLE next cycle.
  - oCAP_END pulses 1 cycle if aborted from ARMED/CAPTURE.
  - oWORD_VALID cleared; counters cleared.
- oSTATE = current state, registered.

Optional Feature:
- Macro FRS_CHECKSUM_EN.
- When defined:
  - Adds output oCHECKSUM[15:0], a modulo-2^16 sum of every word latched into oWORD during READOUT.
  - Cleared in LOAD and held through DONE/ERR.
  - Lets HPS software confirm transfer integrity.
- When undefined: port and adder absent; all other behaviour identical.

Test Plan:
- Reset asserted mid-CAPTURE (pixel count 1000) -> next cycle oSTATE = 0, oCAP_START = 0, oCAP_END = 0, all outputs 0.
- iSTART_REQ rise with iFVAL = 1 -> oWR_LOAD/oRD_LOAD 1-cycle pulse; state stays SYNC until iFVAL = 0; oCAP_START = 1 after; CAPTURE entered on iFVAL rise.
- 307200 iDVAL strobes -> oCAP_END pulses exactly on the cycle after the 307200th strobe; state READOUT; extra strobes ignored.
- READOUT, iRD_DATA = 16'hA5A5 -> iRD_REQ at n gives oFIFO_RD at n+1 and oWORD = A5A5, oWORD_VALID = 1 at n+2. After 40 acks oROW = 1, oCOL = 0. After 19200 acks oDONE = 1.
- iFVAL falls at pixel 5000 -> ERR (oSTATE = 7), oERR = 1, oCAP_END 1-cycle pulse; iSTART_REQ = 0 -> IDLE, oERR = 0.
- iRD_REQ while oWORD_VALID = 1 -> oERR = 1, no oFIFO_RD. With FRS_CHECKSUM_EN and words 1,2,...,40 read -> oCHECKSUM = 16'd820.
